// File: rtl/iob_plic_src_cond.sv
// iob_plic_src_cond -- interrupt source conditioner feeding the PLIC src input.
//
// Each source line is passed through a SYNC_STAGES-deep synchroniser, XORed
// with its polarity bit, debounced by a counter that requires the new level to
// persist for L = max(i_filt_len, 1) cycles, and masked by its enable. The
// filtered level q is the registered output. There is no combinational path
// from any input to o_src_out.
//
// Optional build macro: PLIC_SRC_COND_STATUS_EN
//   Adds a sticky per-source change flag (o_chg) and its clear (i_chg_clr).
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous, active-high reset
//   i_raw_src   [SOURCES]  raw, possibly asynchronous interrupt lines
//   i_pol       [SOURCES]  polarity, 1 = raw line is active-low
//   i_en        [SOURCES]  enable, 0 forces the output and filter state low
//   i_filt_len  [FILT_W]   global debounce length in cycles (0 acts as 1)
//   o_src_out   [SOURCES]  conditioned active-high levels to PLIC src
//   o_chg       [SOURCES]  (macro only) sticky "q toggled" flag
//   i_chg_clr   [SOURCES]  (macro only) one-cycle clear for o_chg

module iob_plic_src_cond_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_raw,
  input  logic              i_pol,
  input  logic              i_en,
  input  logic [FILT_W-1:0] i_lm1,   // L-1, shared by all lanes
`ifdef PLIC_SRC_COND_STATUS_EN
  input  logic              i_chg_clr,
  output logic              o_chg,
`endif
  output logic              o_q
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_q;
  logic [FILT_W-1:0]      r_cnt;
  logic                   w_s;
  logic                   w_tgl;

  // Plain flop chain: no logic between stages.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};

  assign w_s   = r_sync[SYNC_STAGES-1] ^ i_pol;
  // >= rather than == so a shrinking filt_len toggles at once and cnt never wraps.
  assign w_tgl = i_en && (w_s != r_q) && (r_cnt >= i_lm1);

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (!i_en) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (w_s == r_q) begin
      r_cnt <= '0;
    end else if (w_tgl) begin
      r_q   <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end

  assign o_q = r_q;

`ifdef PLIC_SRC_COND_STATUS_EN
  logic r_chg;
  // Set has priority over clear.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)          r_chg <= 1'b0;
    else if (w_tgl)     r_chg <= 1'b1;
    else if (i_chg_clr) r_chg <= 1'b0;
  assign o_chg = r_chg;
`endif

endmodule

module iob_plic_src_cond #(
  parameter int SOURCES     = 64,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SOURCES-1:0] i_raw_src,
  input  logic [SOURCES-1:0] i_pol,
  input  logic [SOURCES-1:0] i_en,
  input  logic [FILT_W-1:0]  i_filt_len,
`ifdef PLIC_SRC_COND_STATUS_EN
  input  logic [SOURCES-1:0] i_chg_clr,
  output logic [SOURCES-1:0] o_chg,
`endif
  output logic [SOURCES-1:0] o_src_out
);

  logic [FILT_W-1:0] w_lm1;

  // L = max(filt_len, 1), so L-1 is 0 for both 0 and 1.
  assign w_lm1 = (i_filt_len == '0) ? '0 : i_filt_len - 1'b1;

  for (genvar g = 0; g < SOURCES; g++) begin : g_lane
    iob_plic_src_cond_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raw     (i_raw_src[g]),
      .i_pol     (i_pol[g]),
      .i_en      (i_en[g]),
      .i_lm1     (w_lm1),
`ifdef PLIC_SRC_COND_STATUS_EN
      .i_chg_clr (i_chg_clr[g]),
      .o_chg     (o_chg[g]),
`endif
      .o_q       (o_src_out[g])
    );
  end

endmodule

// File: doc/iob_plic_src_cond.md
Name: iob_plic_src_cond

Overview:
- Interrupt source conditioner placed directly upstream of the PLIC; its src_out drives the PLIC src input bit-for-bit.
- Per source: synchronises the raw, possibly asynchronous, line into clk; applies a polarity select; debounces with a programmable length; masks with an enable.
- The PLIC therefore only sees clean, clk-synchronous, active-high levels.

Parameters:
- SOURCES, 64: number of interrupt source lines; must match the PLIC SOURCES.
- SYNC_STAGES, 2: synchroniser flop depth; minimum 2.
- FILT_W, 4: debounce counter and filt_len width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- raw_src  in  SOURCES  unsynchronised interrupt lines from peripherals/pads
- pol  in  SOURCES  per-source polarity, 1 = active-low raw line; quasi-static, clk domain
- en  in  SOURCES  per-source enable, 0 = output forced low; clk domain
- filt_len  in  FILT_W  global debounce length in cycles; clk domain
- src_out  out  SOURCES  conditioned levels to PLIC src

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock. All synchroniser flops, all filtered state q, and all counters cnt reset to 0; src_out = 0.
- Synchroniser:
  - SYNC_STAGES flops per bit, no logic between stages.
  - y = last stage output.
- Polarity:
  - s = y XOR pol, applied after synchronisation.
  - A pol change goes through the debounce filter like any input change; there is no bypass.
- Per-source filter state: q (1 bit) and cnt (FILT_W bits). Let L = max(filt_len, 1).
  - en = 0: q <= 0 and cnt <= 0 every cycle.
  - s == q: cnt <= 0.
  - s != q and cnt >= L-1: q <= s, cnt <= 0.
  - s != q otherwise: cnt <= cnt + 1. No wrap is possible because of the >= compare.
- Latency:
  - A stable raw change is visible on src_out exactly SYNC_STAGES + L clk edges after it is first sampled.
  - Pulses that differ from q for fewer than L consecutive cycles are rejected completely; cnt restarts at 0.
- filt_len change mid-count:
  - Takes effect on the next cycle.
  - If cnt >= new L-1, q toggles on that cycle.
- en 0->1:
  - Filtering restarts from q = 0.
  - An asserted source appears after L cycles, not immediately.
- After reset with pol = 1 and raw = 0: s = 1, so src_out rises after SYNC_STAGES + L cycles. This is intentional: software programs pol before enabling.
- src_out = q, registered. There is no combinational path from any input to src_out.
- Sources are fully independent; there is no cross-source state.

Optional Feature:
- Macro: PLIC_SRC_COND_STATUS_EN.
- Defined: adds ports chg (out, SOURCES) and chg_clr (in, SOURCES).
  - chg[i] is a sticky flag, reset 0.
  - Set on the cycle q[i] toggles in either direction.
  - Cleared by a one-cycle chg_clr[i] pulse.
  - Set wins over clear on the same cycle.
- Undefined: chg and chg_clr do not exist; no extra flops.

Test Plan:
- Reset/default: hold rst 3 cycles with raw_src = 0, pol = 0, en = all 1, filt_len = 4 -> src_out = 0 during and after reset, for all 64 bits.
- Basic latency: filt_len = 4, raw_src[5] rises and stays high -> src_out[5] rises exactly 6 edges after first sample; all other bits stay 0.
- Glitch reject: filt_len = 4, raw_src[7] high for 3 cycles then low -> src_out[7] stays 0. Repeat with 4 cycles high -> src_out[7] pulses high for 4 cycles, starting 6 cycles after the rise.
- Polarity/enable:
  - pol[2] = 1, raw_src[2] = 0, en[2] = 1, filt_len = 0 -> src_out[2] = 1 after 3 cycles.
  - Then en[2] = 0 -> src_out[2] = 0 next cycle.
- filt_len shrink: filt_len = 15, raw_src[9] high for 8 cycles, then filt_len set to 5 -> src_out[9] toggles on the next cycle, since cnt >= 4.
- Status (with macro): src_out[1] rises -> chg[1] = 1. Apply chg_clr[1] on the same cycle as a falling toggle -> chg[1] remains 1; a later lone chg_clr[1] -> chg[1] = 0.
